// File: rtl/config_reg_bank.sv
// Double-buffered configuration register bank.
// Host writes land in a shadow bank and are copied to the active bank on a
// COMMIT command. Writes to the command register are not stored. Each set
// bit starts a self-clearing pulse that lasts PULSE_LEN cycles.
// Any register can be read back from either bank.
// Optional feature macro: CFG_PARITY_EN (per-register even parity checking).
module config_reg_bank #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 8,
    parameter int NUM_REGS  = 20,
    parameter int CTRL_ADDR = 0,
    parameter int CMD_ADDR  = 1,
    parameter int PULSE_LEN = 4
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       wr_in,
    input  logic [ADDR_W-1:0]          wr_addr_in,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       rd_en_in,
    input  logic [ADDR_W-1:0]          rd_addr_in,
    input  logic                       rd_sel_active_in,
    output logic [NUM_REGS*DATA_W-1:0] cfg_flat_out,
    output logic [DATA_W-1:0]          ctrl_reg_out,
    output logic [DATA_W-1:0]          cmd_pulse_out,
    output logic                       commit_done_out,
    output logic [NUM_REGS-1:0]        config_received_out,
    output logic                       all_received_out,
    output logic [DATA_W-1:0]          rd_data_out,
    output logic                       rd_valid_out,
    output logic                       addr_err_out,
    output logic                       parity_err_out
);

    localparam int                 CNT_W    = $clog2(PULSE_LEN + 1);
    localparam logic [ADDR_W:0]    NREGS_X  = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0]  CTRL_A   = ADDR_W'(CTRL_ADDR);
    localparam logic [ADDR_W-1:0]  CMD_A    = ADDR_W'(CMD_ADDR);
    localparam logic [NUM_REGS-1:0] CMD_MASK = NUM_REGS'(1) << CMD_ADDR;

    logic [DATA_W-1:0]   shadow [NUM_REGS];
    logic [DATA_W-1:0]   active [NUM_REGS];
    logic [CNT_W-1:0]    pulse_cnt [DATA_W];
    logic [NUM_REGS-1:0] recv_next;
    logic [DATA_W-1:0]   rd_word;

    logic wr_in_range, rd_in_range;
    logic wr_cmd, wr_ctrl, wr_data;
    logic do_commit, clr_recv, clr_err;
    logic wr_oob, rd_oob;

    assign wr_in_range = ({1'b0, wr_addr_in} < NREGS_X);
    assign rd_in_range = ({1'b0, rd_addr_in} < NREGS_X);
    assign wr_cmd      = wr_in && wr_in_range && (wr_addr_in == CMD_A);
    assign wr_ctrl     = wr_in && wr_in_range && (wr_addr_in == CTRL_A);
    assign wr_data     = wr_in && wr_in_range && !wr_cmd && !wr_ctrl;
    assign wr_oob      = wr_in && !wr_in_range;
    assign rd_oob      = rd_en_in && !rd_in_range;
    assign do_commit   = wr_cmd && data_in[0];
    assign clr_recv    = wr_cmd && data_in[1];
    assign clr_err     = wr_cmd && data_in[2];

    // Flatten the active bank for the trigger logic.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign cfg_flat_out[g*DATA_W +: DATA_W] = active[g];
    end
    assign ctrl_reg_out = active[CTRL_ADDR];

    // Stretched pulses: a command bit is high while its counter is nonzero.
    for (genvar g = 0; g < DATA_W; g++) begin : g_pulse
        assign cmd_pulse_out[g] = (pulse_cnt[g] != '0);
    end

    // Shadow takes host writes; active takes control writes or a full commit copy.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if ((wr_data || wr_ctrl) && (wr_addr_in == ADDR_W'(i)))
                    shadow[i] <= data_in;
                if (wr_ctrl && (wr_addr_in == ADDR_W'(i)))
                    active[i] <= data_in;
                else if (do_commit)
                    active[i] <= shadow[i];
            end
        end
    end

    // Pulse counters reload on a command write and otherwise count down to zero.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < DATA_W; i++) pulse_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < DATA_W; i++) begin
                if (wr_cmd && data_in[i])
                    pulse_cnt[i] <= CNT_W'(PULSE_LEN);
                else if (pulse_cnt[i] != '0)
                    pulse_cnt[i] <= pulse_cnt[i] - 1'b1;
            end
        end
    end

    // One-cycle acknowledge following the commit edge.
    always_ff @(posedge clk_in) begin
        if (rst_in) commit_done_out <= 1'b0;
        else        commit_done_out <= do_commit;
    end

    // Next received bitmap: clear first, then mark a stored write.
    always_comb begin
        recv_next = clr_recv ? '0 : config_received_out;
        for (int i = 0; i < NUM_REGS; i++) begin
            if ((wr_data || wr_ctrl) && (wr_addr_in == ADDR_W'(i)))
                recv_next[i] = 1'b1;
        end
    end

    // Register the bitmap and its summary together so they never disagree.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            config_received_out <= '0;
            all_received_out    <= 1'b0;
        end else begin
            config_received_out <= recv_next;
            all_received_out    <= &(recv_next | CMD_MASK);
        end
    end

    // Read mux: command register and unmapped addresses read as zero.
    always_comb begin
        rd_word = '0;
        if (rd_addr_in != CMD_A) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (rd_addr_in == ADDR_W'(i))
                    rd_word = rd_sel_active_in ? active[i] : shadow[i];
            end
        end
    end

    // Registered readback; data holds when no read is requested.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rd_data_out  <= '0;
            rd_valid_out <= 1'b0;
        end else begin
            rd_valid_out <= rd_en_in;
            if (rd_en_in) rd_data_out <= rd_word;
        end
    end

    // Sticky address error; a new error outranks a simultaneous clear.
    always_ff @(posedge clk_in) begin
        if (rst_in)                 addr_err_out <= 1'b0;
        else if (wr_oob || rd_oob)  addr_err_out <= 1'b1;
        else if (clr_err)           addr_err_out <= 1'b0;
    end

`ifdef CFG_PARITY_EN
    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

    logic [NUM_REGS-1:0] par_shadow, par_active;
    logic                par_mismatch;
    logic                par_inject;

    assign par_inject = wr_in && (wr_addr_in == ADDR_W'(NUM_REGS - 1)) &&
                        (data_in == {DATA_W{1'b1}}) && (CTRL_ADDR == 0);

    // Parity bits follow their registers; the inject hook corrupts register 0.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            par_shadow <= '0;
            par_active <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if ((wr_data || wr_ctrl) && (wr_addr_in == ADDR_W'(i)))
                    par_shadow[i] <= even_parity(data_in);
                if (wr_ctrl && (wr_addr_in == ADDR_W'(i)))
                    par_active[i] <= even_parity(data_in);
                else if (do_commit)
                    par_active[i] <= par_shadow[i];
            end
            if (par_inject) begin
                par_shadow[0] <= ~par_shadow[0];
                par_active[0] <= ~par_active[0];
            end
        end
    end

    // Continuous check of every active register against its stored parity.
    always_comb begin
        par_mismatch = 1'b0;
        for (int i = 0; i < NUM_REGS; i++)
            if (even_parity(active[i]) != par_active[i]) par_mismatch = 1'b1;
    end

    // Sticky parity error, cleared by CLR_ERR unless a mismatch persists.
    always_ff @(posedge clk_in) begin
        if (rst_in)            parity_err_out <= 1'b0;
        else if (par_mismatch) parity_err_out <= 1'b1;
        else if (clr_err)      parity_err_out <= 1'b0;
    end
`else
    assign parity_err_out = 1'b0;
`endif

endmodule

// File: tb/tb_config_reg_bank.sv
// Directed testbench for config_reg_bank using the default parameters.
module tb_config_reg_bank;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 8;
    localparam int NUM_REGS = 20;

    logic                       clk_in = 1'b0;
    logic                       rst_in;
    logic                       wr_in;
    logic [ADDR_W-1:0]          wr_addr_in;
    logic [DATA_W-1:0]          data_in;
    logic                       rd_en_in;
    logic [ADDR_W-1:0]          rd_addr_in;
    logic                       rd_sel_active_in;
    logic [NUM_REGS*DATA_W-1:0] cfg_flat_out;
    logic [DATA_W-1:0]          ctrl_reg_out;
    logic [DATA_W-1:0]          cmd_pulse_out;
    logic                       commit_done_out;
    logic [NUM_REGS-1:0]        config_received_out;
    logic                       all_received_out;
    logic [DATA_W-1:0]          rd_data_out;
    logic                       rd_valid_out;
    logic                       addr_err_out;
    logic                       parity_err_out;

    int checks = 0;
    int errors = 0;

    config_reg_bank dut (
        .clk_in(clk_in), .rst_in(rst_in), .wr_in(wr_in), .wr_addr_in(wr_addr_in),
        .data_in(data_in), .rd_en_in(rd_en_in), .rd_addr_in(rd_addr_in),
        .rd_sel_active_in(rd_sel_active_in), .cfg_flat_out(cfg_flat_out),
        .ctrl_reg_out(ctrl_reg_out), .cmd_pulse_out(cmd_pulse_out),
        .commit_done_out(commit_done_out), .config_received_out(config_received_out),
        .all_received_out(all_received_out), .rd_data_out(rd_data_out),
        .rd_valid_out(rd_valid_out), .addr_err_out(addr_err_out),
        .parity_err_out(parity_err_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_in = 1'b1;
        wr_addr_in = a;
        data_in = d;
    endtask

    initial begin
        rst_in = 1'b1; wr_in = 1'b0; wr_addr_in = '0; data_in = '0;
        rd_en_in = 1'b0; rd_addr_in = '0; rd_sel_active_in = 1'b0;
        tick(); tick();
        chk("rst_flat_zero", 32'(cfg_flat_out == '0), 32'd1);
        chk("rst_pulse", 32'(cmd_pulse_out), 32'h0);
        chk("rst_recv", 32'(config_received_out), 32'h0);
        chk("rst_rd_valid", 32'(rd_valid_out), 32'h0);
        chk("rst_addr_err", 32'(addr_err_out), 32'h0);
        chk("parity_err_off", 32'(parity_err_out), 32'h0);
        rst_in = 1'b0;

        // Shadow write then commit
        set_wr(8'd3, 16'h0055); tick(); wr_in = 1'b0;
        chk("recv_bit3", 32'(config_received_out), 32'h8);
        chk("active3_before_commit", 32'(cfg_flat_out[3*DATA_W +: DATA_W]), 32'h0);
        set_wr(8'd1, 16'h0001); tick(); wr_in = 1'b0;
        chk("active3_after_commit", 32'(cfg_flat_out[3*DATA_W +: DATA_W]), 32'h0055);
        chk("commit_done_hi", 32'(commit_done_out), 32'h1);
        chk("cmd_not_recv", 32'(config_received_out), 32'h8);
        tick();
        chk("commit_done_lo", 32'(commit_done_out), 32'h0);

        // Control register bypasses the shadow bank
        set_wr(8'd0, 16'h0005); tick(); wr_in = 1'b0;
        chk("ctrl_direct", 32'(ctrl_reg_out), 32'h0005);
        repeat (6) tick();
        chk("pulses_idle", 32'(cmd_pulse_out), 32'h0);

        // Retriggered pulse stays high for 2 + PULSE_LEN cycles
        for (int k = 0; k < 8; k++) begin
            if (k == 0 || k == 2) set_wr(8'd1, 16'h0010);
            tick();
            wr_in = 1'b0;
            chk($sformatf("pulse4_cyc%0d", k), 32'(cmd_pulse_out[4]), (k < 6) ? 32'h1 : 32'h0);
        end

        // Fill every register except the command register
        for (int k = 0; k < NUM_REGS; k++) begin
            if (k == 1) continue;
            set_wr(ADDR_W'(k), 16'h0100 + 16'(k)); tick(); wr_in = 1'b0;
            if (k == NUM_REGS - 2) chk("all_recv_not_yet", 32'(all_received_out), 32'h0);
        end
        chk("all_recv_set", 32'(all_received_out), 32'h1);
        chk("recv_full", 32'(config_received_out), 32'hFFFFD);
        set_wr(8'd1, 16'h0002); tick(); wr_in = 1'b0;
        chk("recv_cleared", 32'(config_received_out), 32'h0);
        chk("all_recv_cleared", 32'(all_received_out), 32'h0);

        // Out-of-range accesses
        set_wr(8'd25, 16'hBEEF); tick(); wr_in = 1'b0;
        chk("addr_err_wr", 32'(addr_err_out), 32'h1);
        rd_en_in = 1'b1; rd_addr_in = 8'd30; tick(); rd_en_in = 1'b0;
        chk("oob_rd_valid", 32'(rd_valid_out), 32'h1);
        chk("oob_rd_data", 32'(rd_data_out), 32'h0);
        tick();
        chk("rd_valid_one_cycle", 32'(rd_valid_out), 32'h0);
        set_wr(8'd1, 16'h0004); tick(); wr_in = 1'b0;
        chk("addr_err_cleared", 32'(addr_err_out), 32'h0);
        set_wr(8'd1, 16'h0004); rd_en_in = 1'b1; rd_addr_in = 8'd30; tick();
        wr_in = 1'b0; rd_en_in = 1'b0;
        chk("addr_err_set_wins", 32'(addr_err_out), 32'h1);

        // Shadow versus active readback
        set_wr(8'd5, 16'h1234); tick();
        set_wr(8'd1, 16'h0001); tick();
        set_wr(8'd5, 16'h5678); tick(); wr_in = 1'b0;
        chk("active5_kept", 32'(cfg_flat_out[5*DATA_W +: DATA_W]), 32'h1234);
        rd_en_in = 1'b1; rd_addr_in = 8'd5; rd_sel_active_in = 1'b1; tick();
        chk("rd_active5", 32'(rd_data_out), 32'h1234);
        rd_sel_active_in = 1'b0; tick();
        chk("rd_shadow5", 32'(rd_data_out), 32'h5678);
        chk("rd_b2b_valid", 32'(rd_valid_out), 32'h1);
        set_wr(8'd5, 16'h9ABC); tick(); wr_in = 1'b0;
        chk("rd_same_cycle_old", 32'(rd_data_out), 32'h5678);
        rd_en_in = 1'b0; tick();
        chk("rd_hold_data", 32'(rd_data_out), 32'h5678);
        chk("rd_hold_valid", 32'(rd_valid_out), 32'h0);
        rd_en_in = 1'b1; rd_addr_in = 8'd1; tick(); rd_en_in = 1'b0;
        chk("rd_cmd_zero", 32'(rd_data_out), 32'h0);
        rd_en_in = 1'b1; rd_addr_in = 8'd5; tick(); rd_en_in = 1'b0;
        chk("rd_shadow5_new", 32'(rd_data_out), 32'h9ABC);

        // Reset in the middle of a pulse
        set_wr(8'd1, 16'h00FF); tick(); wr_in = 1'b0;
        chk("pulse_ff", 32'(cmd_pulse_out), 32'h00FF);
        rst_in = 1'b1; tick();
        chk("rst_mid_pulse", 32'(cmd_pulse_out), 32'h0);
        chk("rst_mid_flat", 32'(cfg_flat_out == '0), 32'd1);
        chk("rst_mid_ctrl", 32'(ctrl_reg_out), 32'h0);
        chk("rst_mid_commit", 32'(commit_done_out), 32'h0);
        chk("rst_mid_rd_data", 32'(rd_data_out), 32'h0);
        chk("rst_mid_addr_err", 32'(addr_err_out), 32'h0);
        rst_in = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
